// File: rtl/mod_n_counter.sv
// Modulo-N counter stage with IDLE/RUN/PAUSE control, up/down stepping,
// clamped parallel load and a same-cycle carry/borrow for cascading.
module mod_n_counter #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             cin,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             cout,
  output logic             tc,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] next_count;
  logic             step;

  // Terminal count follows direction; carry/borrow only on an actual wrapping step
  always_comb begin
    tc   = up ? (count == MAX_COUNT) : (count == '0);
    step = running & cin & ~clear & ~load & ~stop & ~reset;
    cout = step & tc;
  end

  // Next state and next count in priority order: clear, load, stop, start/step
  always_comb begin
    next_state = state;
    next_count = count;
    if (clear) begin
      next_state = IDLE;
      next_count = '0;
    end else if (load) begin
      next_count = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
    end else if (stop) begin
      if (state == RUN) begin
        next_state = PAUSE;
      end
    end else begin
      if (start && (state != RUN)) begin
        next_state = RUN;
      end
      if (step) begin
        if (up) begin
          next_count = (count == MAX_COUNT) ? '0 : count + WIDTH'(1);
        end else begin
          next_count = (count == '0) ? MAX_COUNT : count - WIDTH'(1);
        end
      end
    end
  end

  // State, count and running flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      count   <= next_count;
      running <= (next_state == RUN);
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: reset/idle, up and down wrap, pause and
// priority, load clamp, clear, reset mid-count and a two-stage cascade.
module tb_mod_n_counter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // a: MOD10 W4
  logic       a_start, a_stop, a_clear, a_cin, a_up, a_load;
  logic [3:0] a_load_value, a_count;
  logic       a_cout, a_tc, a_running;
  // b: MOD60 W6
  logic       b_start, b_stop, b_clear, b_cin, b_up, b_load;
  logic [5:0] b_load_value, b_count;
  logic       b_cout, b_tc, b_running;
  // c: MOD24 W5
  logic       c_start, c_stop, c_clear, c_cin, c_up, c_load;
  logic [4:0] c_load_value, c_count;
  logic       c_cout, c_tc, c_running;
  // cascade: lo MOD10 W4 feeding hi MOD6 W3
  logic       k_start;
  logic [3:0] lo_count;
  logic [2:0] hi_count;
  logic       lo_cout, lo_tc, lo_running, hi_cout, hi_tc, hi_running;

  mod_n_counter #(.MODULUS(10), .WIDTH(4)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .clear(a_clear),
    .cin(a_cin), .up(a_up), .load(a_load), .load_value(a_load_value),
    .count(a_count), .cout(a_cout), .tc(a_tc), .running(a_running));

  mod_n_counter #(.MODULUS(60), .WIDTH(6)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .clear(b_clear),
    .cin(b_cin), .up(b_up), .load(b_load), .load_value(b_load_value),
    .count(b_count), .cout(b_cout), .tc(b_tc), .running(b_running));

  mod_n_counter #(.MODULUS(24), .WIDTH(5)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .stop(c_stop), .clear(c_clear),
    .cin(c_cin), .up(c_up), .load(c_load), .load_value(c_load_value),
    .count(c_count), .cout(c_cout), .tc(c_tc), .running(c_running));

  mod_n_counter #(.MODULUS(10), .WIDTH(4)) u_lo (
    .clk(clk), .reset(reset), .start(k_start), .stop(1'b0), .clear(1'b0),
    .cin(1'b1), .up(1'b1), .load(1'b0), .load_value(4'd0),
    .count(lo_count), .cout(lo_cout), .tc(lo_tc), .running(lo_running));

  mod_n_counter #(.MODULUS(6), .WIDTH(3)) u_hi (
    .clk(clk), .reset(reset), .start(k_start), .stop(1'b0), .clear(1'b0),
    .cin(lo_cout), .up(1'b1), .load(1'b0), .load_value(3'd0),
    .count(hi_count), .cout(hi_cout), .tc(hi_tc), .running(hi_running));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_down [4];
    int exp_dcout[4];
    int hi_cout_cycles;

    reset = 1'b1;
    {a_start, a_stop, a_clear, a_cin, a_up, a_load} = 6'b0;
    {b_start, b_stop, b_clear, b_cin, b_up, b_load} = 6'b0;
    {c_start, c_stop, c_clear, c_cin, c_up, c_load} = 6'b0;
    a_load_value = '0; b_load_value = '0; c_load_value = '0;
    k_start = 1'b0;

    // Reset for two cycles with start held: reset dominates
    a_start = 1'b1; a_up = 1'b1; a_cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_count", 32'(a_count), 0);
      check("rst_running", 32'(a_running), 0);
      check("rst_cout", 32'(a_cout), 0);
    end
    check("rst_tc_up", 32'(a_tc), 0);
    a_up = 1'b0; #1;
    check("rst_tc_down", 32'(a_tc), 1);
    check("rst_cout_down", 32'(a_cout), 0);
    a_up = 1'b1;

    // Idle after reset: nothing moves; stop in IDLE is ignored
    reset = 1'b0; a_start = 1'b0; a_stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_count", 32'(a_count), 0);
      check("idle_running", 32'(a_running), 0);
    end
    a_stop = 1'b0;

    // Up wrap MOD10: entry edge does not count, then 1..9,0
    a_start = 1'b1;
    tick();
    check("up_entry_running", 32'(a_running), 1);
    check("up_entry_count", 32'(a_count), 0);
    for (int i = 1; i <= 10; i++) begin
      check("up_cout", 32'(a_cout), (i == 10) ? 1 : 0);
      tick();
      check("up_count", 32'(a_count), i % 10);
      check("up_running", 32'(a_running), 1);
    end

    // Advance to 4, then stop and hold
    for (int i = 0; i < 4; i++) tick();
    check("pre_stop_count", 32'(a_count), 4);
    a_start = 1'b0; a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pause_count", 32'(a_count), 4);
      check("pause_running", 32'(a_running), 0);
      tick();
    end
    // start and stop together: stop wins, stays paused
    a_start = 1'b1; a_stop = 1'b1;
    tick();
    check("both_running", 32'(a_running), 0);
    check("both_count", 32'(a_count), 4);
    a_stop = 1'b0;
    tick();
    check("resume_running", 32'(a_running), 1);
    check("resume_entry_count", 32'(a_count), 4);
    tick();
    check("resume_step", 32'(a_count), 5);

    // Down wrap MOD60: load 2, start, count down through 0 to 59, 58
    b_load = 1'b1; b_load_value = 6'd2; b_cin = 1'b1; b_up = 1'b0;
    tick();
    check("dn_load", 32'(b_count), 2);
    b_load = 1'b0; b_start = 1'b1;
    tick();
    check("dn_entry_running", 32'(b_running), 1);
    check("dn_entry_count", 32'(b_count), 2);
    exp_down  = '{1, 0, 59, 58};
    exp_dcout = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      check("dn_cout", 32'(b_cout), 32'(exp_dcout[i]));
      tick();
      check("dn_count", 32'(b_count), 32'(exp_down[i]));
    end
    // Direction change: up now, 58 -> 59 -> 0 with carry
    b_up = 1'b1; #1;
    check("dir_tc_58", 32'(b_tc), 0);
    tick();
    check("dir_count_59", 32'(b_count), 59);
    check("dir_tc_59", 32'(b_tc), 1);
    check("dir_cout_59", 32'(b_cout), 1);
    tick();
    check("dir_count_0", 32'(b_count), 0);

    // Load clamp MOD24: 30 -> 23; not running so no carry
    c_up = 1'b1; c_cin = 1'b1; c_load = 1'b1; c_load_value = 5'd30;
    tick();
    check("clamp_count", 32'(c_count), 23);
    check("clamp_tc", 32'(c_tc), 1);
    check("clamp_cout", 32'(c_cout), 0);
    c_load = 1'b0; c_start = 1'b1;
    tick();
    check("c_run", 32'(c_running), 1);
    // Load in RUN with cin: loaded value, no step, state kept
    c_load = 1'b1; c_load_value = 5'd7;
    #1;
    check("load_run_cout", 32'(c_cout), 0);
    tick();
    check("load_run_count", 32'(c_count), 7);
    check("load_run_running", 32'(c_running), 1);
    c_load = 1'b0;
    tick();
    check("after_load_step", 32'(c_count), 8);
    // Clear in RUN
    c_clear = 1'b1;
    tick();
    check("clear_count", 32'(c_count), 0);
    check("clear_running", 32'(c_running), 0);
    c_clear = 1'b0;
    tick();
    check("clear_entry_running", 32'(c_running), 1);
    check("clear_entry_count", 32'(c_count), 0);
    // Reset mid-count at terminal count: no carry, back to 0/IDLE
    c_load = 1'b1; c_load_value = 5'd23;
    tick();
    c_load = 1'b0; #1;
    check("pre_rst_cout", 32'(c_cout), 1);
    reset = 1'b1; #1;
    check("rst_mid_cout", 32'(c_cout), 0);
    tick();
    check("rst_mid_count", 32'(c_count), 0);
    check("rst_mid_running", 32'(c_running), 0);
    reset = 1'b0; c_start = 1'b0;

    // Cascade MOD10 -> MOD6
    k_start = 1'b1;
    tick();
    check("casc_running", 32'(hi_running), 1);
    hi_cout_cycles = 0;
    for (int i = 0; i < 59; i++) begin
      if (hi_cout) hi_cout_cycles++;
      tick();
    end
    check("casc_hi_59", 32'(hi_count), 5);
    check("casc_lo_59", 32'(lo_count), 9);
    check("casc_hi_cout_at_59", 32'(hi_cout), 1);
    hi_cout_cycles++;
    tick();
    check("casc_hi_wrap", 32'(hi_count), 0);
    check("casc_lo_wrap", 32'(lo_count), 0);
    if (hi_cout) hi_cout_cycles++;
    check("casc_hi_cout_cycles", 32'(hi_cout_cycles), 1);
    tick();
    check("casc_lo_after", 32'(lo_count), 1);
    check("casc_hi_after", 32'(hi_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
